mem_access_ctrl: RTL

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

---
 rtl/mem_access_ctrl_pkg.sv | 19 +
 rtl/mem_access_ctrl_arbiter.sv | 42 ++++
 rtl/mem_access_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/mem_access_ctrl_pkg.sv
// Shared constants for the memory access controller: FSM state encoding,
// access size codes, requester owner IDs and the default abort timeout.
package mem_access_ctrl_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_ISSUE    = 2'd1;
  localparam logic [1:0] ST_WAIT_MOC = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DT = 1'b1;

  localparam int TIMEOUT_CYCLES_DEF = 15;

endpackage

// File: rtl/mem_access_ctrl_arbiter.sv
// Fixed-priority request select for the memory access controller.
// Data requests beat instruction fetches; a fetch is always a word read.
module mac_arbiter
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dt_req,
  input  logic              dt_rw,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [31:0]       dt_wdata,
  input  logic [1:0]        dt_size,
  output logic              grant,
  output logic              sel_owner,
  output logic              sel_rw,
  output logic [ADDR_W-1:0] sel_addr,
  output logic [31:0]       sel_wdata,
  output logic [1:0]        sel_size
);

  assign grant = dt_req | if_req;

  // Mux the winning requester's transaction fields
  always_comb begin
    if (dt_req) begin
      sel_owner = OWN_DT;
      sel_rw    = dt_rw;
      sel_addr  = dt_addr;
      sel_wdata = dt_wdata;
      sel_size  = dt_size;
    end else begin
      sel_owner = OWN_IF;
      sel_rw    = 1'b1;
      sel_addr  = if_addr;
      sel_wdata = '0;
      sel_size  = SZ_WORD;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory access controller: arbitrates fetch/data requests onto a single
// MFA/MOC memory handshake. Optional MAC_TIMEOUT_EN adds a WAIT_MOC abort
// timer with a sticky err flag.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | no transaction; latch winner when any request is high
//   ST_ISSUE    | first mfa cycle with latched transaction
//   ST_WAIT_MOC | mfa held until mem_moc (or timeout)
//   ST_DONE     | mfa low, one-cycle done pulse to the owner
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              dt_req,
  input  logic              dt_rw,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [31:0]       dt_wdata,
  input  logic [1:0]        dt_size,
  input  logic              mem_moc,
  input  logic [31:0]       mem_rdata,
  output logic              mem_mfa,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_size,
  output logic              if_done,
  output logic              dt_done,
  output logic [31:0]       rdata,
  output logic              busy,
  output logic              err
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  logic [1:0]        state;
  logic              owner;
  logic              grant;
  logic              sel_owner;
  logic              sel_rw;
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [1:0]        sel_size;
  logic              to_hit;

  mac_arbiter #(.ADDR_W(ADDR_W)) u_arb (
    .if_req    (if_req),
    .if_addr   (if_addr),
    .dt_req    (dt_req),
    .dt_rw     (dt_rw),
    .dt_addr   (dt_addr),
    .dt_wdata  (dt_wdata),
    .dt_size   (dt_size),
    .grant     (grant),
    .sel_owner (sel_owner),
    .sel_rw    (sel_rw),
    .sel_addr  (sel_addr),
    .sel_wdata (sel_wdata),
    .sel_size  (sel_size)
  );

  // Decoded from state so mfa falls the instant reset forces IDLE
  assign mem_mfa = (state == ST_ISSUE) || (state == ST_WAIT_MOC);
  assign busy    = (state != ST_IDLE);
  assign if_done = (state == ST_DONE) && (owner == OWN_IF);
  assign dt_done = (state == ST_DONE) && (owner == OWN_DT);

`ifdef MAC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;

  assign to_hit = (state == ST_WAIT_MOC) && !mem_moc &&
                  (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Count WAIT_MOC cycles without moc; err sticks until reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      to_cnt <= '0;
      err    <= 1'b0;
    end else if (state == ST_WAIT_MOC && !mem_moc) begin
      if (to_hit) begin
        to_cnt <= '0;
        err    <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end else begin
      to_cnt <= '0;
    end
  end
`else
  assign to_hit = 1'b0;
  assign err    = 1'b0;
`endif

  // Main sequencer: latch winner in IDLE, hold it until DONE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      owner     <= OWN_IF;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner     <= sel_owner;
            mem_rw    <= sel_rw;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
            mem_size  <= sel_size;
            state     <= ST_ISSUE;
          end
        end
        ST_ISSUE: state <= ST_WAIT_MOC;
        ST_WAIT_MOC: begin
          if (mem_moc) begin
            if (mem_rw) rdata <= mem_rdata;
            state <= ST_DONE;
          end else if (to_hit) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
